cp0_exc_unit: RTL and testbench
===============================

# cp0_exc_unit

Coprocessor-0 exception responder for the single-issue MIPS core. Consumes the exception and privilege strobes produced by the instruction decoder (`int_cause`, `cause_write`, `exit_kernel`, `write_c0`) and holds the architectural Status, Cause and EPC registers. Drives the privilege-mode flag back to the decoder and issues a one-cycle PC redirect to the exception vector or to EPC. Sits beside the register file in the datapath; `c0_rdata` feeds the `movrf` write-back path.

## Interface
- `VECTOR`, 32'h0000_0180, exception/interrupt handler entry address
- `W`, 32, PC and data width
- `clk` in 1, core clock
- `reset_n` in 1, asynchronous active-low reset
- `instr_valid` in 1, current instruction is real (not stall or bubble); all strobes are ignored when 0
- `pc` in W, address of the current instruction
- `cause_write` in 1, decoder signals a synchronous exception
- `int_cause` in 3, exception code: 1 overflow, 2 privileged op in user mode, 3 illegal op/funct
- `exit_kernel` in 1, exk instruction
- `write_c0` in 1, movc0 instruction
- `c0_sel` in 2, C0 register select: 0 Status, 1 Cause, 2 EPC, 3 reserved
- `c0_wdata` in W, movc0 data
- `ext_irq` in 1, asynchronous external interrupt, level-sensitive
- `c0_rdata` out W, combinational read of `c0_sel`; sel 3 reads 0
- `kernel_mode` out 1, Status.UM; 1 = user mode (privileged ops trap), 0 = kernel mode
- `redirect` out 1, one-cycle PC override; also squashes the current instruction's register and memory writes
- `redirect_pc` out W, target when `redirect`=1, else 0

## Operation
- Status fields: bit0 IE, bit1 UM, bit2 PUM (previous UM), bit3 PIE (previous IE); bits 31:4 read 0.
- Cause fields: bits 2:0 code (4 = external interrupt); bits 31:3 read 0.
- FSM states: RUN, ENTER, RETURN.
- RUN, `instr_valid` & `cause_write` performs synchronous entry:
  - Cause <= `int_cause`
  - EPC <= `pc` only if UM=1; a nested fault in kernel mode preserves EPC
  - PUM <= UM, PIE <= IE, UM <= 0, IE <= 0
  - next state ENTER
- RUN, `instr_valid` & ~`cause_write` & irq_sync & IE performs interrupt entry. Same updates as synchronous entry, with Cause <= 4 and EPC <= `pc` unconditionally. The interrupted instruction is squashed and re-executed on return.
- RUN, `instr_valid` & `exit_kernel` & UM=0 & no entry: UM <= PUM, IE <= PIE, next state RETURN.
- RUN, `instr_valid` & `write_c0` & UM=0 & no entry or exit: writes `c0_wdata` to the selected register. Status takes bits 3:0, Cause takes bits 2:0, EPC takes all bits, sel 3 is discarded.
- Priority: `cause_write` > interrupt > `exit_kernel` > `write_c0`. A lower-priority event in the same cycle is dropped.
- ENTER: `redirect`=1, `redirect_pc`=`VECTOR`, all strobes ignored, next state RUN.
- RETURN: `redirect`=1, `redirect_pc`=EPC, all strobes ignored, next state RUN.
- `ext_irq` passes through a 2-flop synchronizer, producing irq_sync. There is no edge latch: a pulse shorter than 2 cycles may be lost.

## Timing
- Reset, asynchronous on `reset_n`=0:
  - Status = 0, so `kernel_mode`=0 (boot in kernel), IE=0
  - Cause = 0, EPC = 0
  - state RUN, `redirect`=0, `redirect_pc`=0, synchronizer flops 0
- Reset during ENTER/RETURN aborts the redirect. The next cycle is RUN with reset values.
- Register updates occur at the clock edge that samples the event. `kernel_mode` changes in the cycle after that edge.
- `redirect` is a registered-state decode, asserted exactly 1 cycle, in the cycle after the event edge.
- Interrupt latency: at most 3 cycles from `ext_irq` rising to the entry edge (2 synchronizer stages plus 1 sample), provided IE=1 and `instr_valid`=1.
- `c0_rdata` has zero latency. A write is visible the cycle after its edge.

## Structure
- Shared package `cp0_pkg`:
  - cause code constants `EXC_NONE`=0, `EXC_OVF`=1, `EXC_PRIV`=2, `EXC_ILL`=3, `EXC_IRQ`=4
  - C0 select constants
  - Status bit-index constants
  - FSM state enum `cp0_state_t`
- One sub-module, `sync2`, the 2-flop synchronizer; it also resets asynchronously on `reset_n`.

## Test plan
- Reset release, then read sel 0/1/2 -> all 0, `kernel_mode`=0, `redirect`=0.
- Kernel writes Status=4'b0101 via movc0, then exk at pc=0x40 with EPC=0x100 -> UM=1, IE=0; redirect to 0x100 for one cycle.
- User mode, `cause_write`, `int_cause`=1, pc=0x204 -> EPC=0x204, Cause=1, UM=0, PUM=1; next cycle redirect to 0x180.
- User mode, IE=1, `ext_irq` raised with `write_c0` asserted on the entry cycle -> Cause=4 within 3 cycles; the movc0 write is dropped; EPC = squashed pc.
- Kernel-mode `cause_write` code 3 with EPC=0x300 -> EPC stays 0x300, Cause=3. Same-cycle `cause_write` and `exit_kernel` -> entry wins, UM stays 0.
- `reset_n` asserted during ENTER -> `redirect` drops immediately; after release all registers are 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants and types for the CP0 exception responder.
// Cause codes, C0 selects, Status bit positions and FSM states.
package cp0_pkg;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_OVF  = 3'd1;
    localparam logic [2:0] EXC_PRIV = 3'd2;
    localparam logic [2:0] EXC_ILL  = 3'd3;
    localparam logic [2:0] EXC_IRQ  = 3'd4;

    localparam logic [1:0] SEL_STATUS = 2'd0;
    localparam logic [1:0] SEL_CAUSE  = 2'd1;
    localparam logic [1:0] SEL_EPC    = 2'd2;
    localparam logic [1:0] SEL_RSVD   = 2'd3;

    localparam int ST_IE  = 0;
    localparam int ST_UM  = 1;
    localparam int ST_PUM = 2;
    localparam int ST_PIE = 3;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_ENTER  = 2'd1,
        S_RETURN = 2'd2
    } cp0_state_t;

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Decoder <-> CP0 bundle: exception strobes in, C0 read data and
// PC redirect back out.
interface cp0_exc_unit_if #(
    parameter int W = 32
);

    logic         instr_valid;
    logic [W-1:0] pc;
    logic         cause_write;
    logic [2:0]   int_cause;
    logic         exit_kernel;
    logic         write_c0;
    logic [1:0]   c0_sel;
    logic [W-1:0] c0_wdata;
    logic [W-1:0] c0_rdata;
    logic         kernel_mode;
    logic         redirect;
    logic [W-1:0] redirect_pc;

    modport master (
        output instr_valid, pc, cause_write, int_cause,
        output exit_kernel, write_c0, c0_sel, c0_wdata,
        input  c0_rdata, kernel_mode, redirect, redirect_pc
    );

    modport slave (
        input  instr_valid, pc, cause_write, int_cause,
        input  exit_kernel, write_c0, c0_sel, c0_wdata,
        output c0_rdata, kernel_mode, redirect, redirect_pc
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous external interrupt level.
module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;
    logic s1_d;
    logic s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception responder: Status/Cause/EPC, exception entry, exk
// return and a one-cycle PC redirect.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter int           W      = 32,
    parameter logic [W-1:0] VECTOR = 32'h0000_0180
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ext_irq,
    cp0_exc_unit_if.slave bus
);

    logic irq_sync;

    sync2 u_sync2 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ext_irq),
        .q       (irq_sync)
    );

    cp0_state_t   state_q, state_d;
    logic [3:0]   status_q, status_d;
    logic [2:0]   cause_q, cause_d;
    logic [W-1:0] epc_q, epc_d;

    logic um;
    logic ie;
    logic go;
    logic do_exc;
    logic do_irq;
    logic do_entry;
    logic do_exit;
    logic do_wr;

    assign um       = status_q[ST_UM];
    assign ie       = status_q[ST_IE];
    assign go       = (state_q == S_RUN) & bus.instr_valid;
    assign do_exc   = go & bus.cause_write;
    assign do_irq   = go & ~bus.cause_write & irq_sync & ie;
    assign do_entry = do_exc | do_irq;
    assign do_exit  = go & ~do_entry & bus.exit_kernel & ~um;
    assign do_wr    = go & ~do_entry & ~do_exit & bus.write_c0 & ~um;

    always_comb begin
        state_d  = S_RUN;
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        if (do_entry) begin
            state_d = S_ENTER;
            cause_d = do_exc ? bus.int_cause : EXC_IRQ;
            // kernel-mode faults keep the original user return address
            if (do_irq | um) begin
                epc_d = bus.pc;
            end
            status_d = {ie, um, 1'b0, 1'b0};
        end else if (do_exit) begin
            state_d         = S_RETURN;
            status_d[ST_UM] = status_q[ST_PUM];
            status_d[ST_IE] = status_q[ST_PIE];
        end else if (do_wr) begin
            case (bus.c0_sel)
                SEL_STATUS: status_d = bus.c0_wdata[3:0];
                SEL_CAUSE:  cause_d  = bus.c0_wdata[2:0];
                SEL_EPC:    epc_d    = bus.c0_wdata;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_RUN;
            status_q <= '0;
            cause_q  <= '0;
            epc_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    always_comb begin
        bus.c0_rdata = '0;
        case (bus.c0_sel)
            SEL_STATUS: bus.c0_rdata = {{(W-4){1'b0}}, status_q};
            SEL_CAUSE:  bus.c0_rdata = {{(W-3){1'b0}}, cause_q};
            SEL_EPC:    bus.c0_rdata = epc_q;
            default:    bus.c0_rdata = '0;
        endcase
    end

    always_comb begin
        bus.redirect_pc = '0;
        case (state_q)
            S_ENTER:  bus.redirect_pc = VECTOR;
            S_RETURN: bus.redirect_pc = epc_q;
            default:  bus.redirect_pc = '0;
        endcase
    end

    assign bus.redirect    = (state_q != S_RUN);
    assign bus.kernel_mode = um;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: reset, movc0, exk, entry,
// interrupt latency, priority and reset during redirect.
module tb_cp0_exc_unit;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic ext_irq = 1'b0;
    int n_run = 0;
    int n_fail = 0;

    cp0_exc_unit_if #(.W(32)) bus ();

    cp0_exc_unit #(
        .W      (32),
        .VECTOR (32'h0000_0180)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ext_irq (ext_irq),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.instr_valid = 1'b0;
        bus.pc          = '0;
        bus.cause_write = 1'b0;
        bus.int_cause   = '0;
        bus.exit_kernel = 1'b0;
        bus.write_c0    = 1'b0;
        bus.c0_sel      = '0;
        bus.c0_wdata    = '0;
    endtask

    task automatic rd(input logic [1:0] sel, input logic [31:0] exp,
                      input string tag);
        bus.c0_sel = sel;
        #1;
        chk(tag, bus.c0_rdata, exp);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] data);
        bus.instr_valid = 1'b1;
        bus.write_c0    = 1'b1;
        bus.c0_sel      = sel;
        bus.c0_wdata    = data;
        tick();
        idle();
    endtask

    initial begin
        idle();
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        rd(2'd0, 32'h0, "rst_status");
        rd(2'd1, 32'h0, "rst_cause");
        rd(2'd2, 32'h0, "rst_epc");
        chk("rst_km", {31'b0, bus.kernel_mode}, 32'h0);
        chk("rst_redir", {31'b0, bus.redirect}, 32'h0);
        chk("rst_rpc", bus.redirect_pc, 32'h0);

        wr(2'd2, 32'h100);
        wr(2'd0, 32'h5);
        rd(2'd0, 32'h5, "status_wr");
        rd(2'd2, 32'h100, "epc_wr");
        bus.instr_valid = 1'b1;
        bus.exit_kernel = 1'b1;
        bus.pc          = 32'h40;
        tick();
        idle();
        chk("exk_redir", {31'b0, bus.redirect}, 32'h1);
        chk("exk_rpc", bus.redirect_pc, 32'h100);
        chk("exk_km", {31'b0, bus.kernel_mode}, 32'h1);
        rd(2'd0, 32'h6, "exk_status");
        tick();
        chk("exk_redir_1cyc", {31'b0, bus.redirect}, 32'h0);
        chk("exk_rpc_0", bus.redirect_pc, 32'h0);

        bus.instr_valid = 1'b1;
        bus.cause_write = 1'b1;
        bus.int_cause   = 3'd1;
        bus.pc          = 32'h204;
        tick();
        idle();
        chk("exc_redir", {31'b0, bus.redirect}, 32'h1);
        chk("exc_rpc", bus.redirect_pc, 32'h180);
        chk("exc_km", {31'b0, bus.kernel_mode}, 32'h0);
        rd(2'd2, 32'h204, "exc_epc");
        rd(2'd1, 32'h1, "exc_cause");
        rd(2'd0, 32'h4, "exc_status");
        tick();
        chk("exc_redir_1cyc", {31'b0, bus.redirect}, 32'h0);

        wr(2'd0, 32'hC);
        bus.instr_valid = 1'b1;
        bus.exit_kernel = 1'b1;
        bus.pc          = 32'h44;
        tick();
        idle();
        chk("exk2_rpc", bus.redirect_pc, 32'h204);
        chk("exk2_km", {31'b0, bus.kernel_mode}, 32'h1);
        rd(2'd0, 32'hF, "exk2_status");
        tick();

        bus.instr_valid = 1'b1;
        bus.write_c0    = 1'b1;
        bus.c0_sel      = 2'd1;
        bus.c0_wdata    = 32'h7;
        bus.pc          = 32'h500;
        ext_irq         = 1'b1;
        tick();
        chk("irq_lat1", {31'b0, bus.redirect}, 32'h0);
        tick();
        chk("irq_lat2", {31'b0, bus.redirect}, 32'h0);
        tick();
        chk("irq_lat3", {31'b0, bus.redirect}, 32'h1);
        idle();
        ext_irq = 1'b0;
        chk("irq_rpc", bus.redirect_pc, 32'h180);
        rd(2'd1, 32'h4, "irq_cause");
        rd(2'd2, 32'h500, "irq_epc");
        rd(2'd0, 32'hC, "irq_status");
        tick();
        chk("irq_redir_1cyc", {31'b0, bus.redirect}, 32'h0);

        wr(2'd2, 32'h300);
        bus.instr_valid = 1'b1;
        bus.cause_write = 1'b1;
        bus.int_cause   = 3'd3;
        bus.exit_kernel = 1'b1;
        bus.pc          = 32'h600;
        tick();
        idle();
        chk("nest_redir", {31'b0, bus.redirect}, 32'h1);
        chk("nest_rpc", bus.redirect_pc, 32'h180);
        chk("nest_km", {31'b0, bus.kernel_mode}, 32'h0);
        rd(2'd2, 32'h300, "nest_epc");
        rd(2'd1, 32'h3, "nest_cause");
        rd(2'd0, 32'h0, "nest_status");
        tick();

        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd0, 32'h0, "sel3_status");
        rd(2'd1, 32'h3, "sel3_cause");
        rd(2'd2, 32'h300, "sel3_epc");
        rd(2'd3, 32'h0, "sel3_read");

        bus.cause_write = 1'b1;
        bus.int_cause   = 3'd2;
        bus.pc          = 32'h800;
        tick();
        idle();
        chk("novalid_redir", {31'b0, bus.redirect}, 32'h0);
        rd(2'd1, 32'h3, "novalid_cause");

        bus.instr_valid = 1'b1;
        bus.cause_write = 1'b1;
        bus.int_cause   = 3'd1;
        bus.pc          = 32'h700;
        tick();
        idle();
        chk("pre_rst_redir", {31'b0, bus.redirect}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_abort_redir", {31'b0, bus.redirect}, 32'h0);
        chk("rst_abort_rpc", bus.redirect_pc, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_redir", {31'b0, bus.redirect}, 32'h0);
        chk("post_rst_km", {31'b0, bus.kernel_mode}, 32'h0);
        rd(2'd0, 32'h0, "post_rst_status");
        rd(2'd1, 32'h0, "post_rst_cause");
        rd(2'd2, 32'h0, "post_rst_epc");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
